ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. It is the sending counterpart to the io_ps2_keyboard receiver and shares the ps2_clk_io/ps2_data_io open-drain pins with it.
- It sends command bytes to the keyboard, e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset.
- It implements the host request-to-send sequence, odd parity, device ACK check and timeouts.
- The top level ties each *_oe output to an open-drain pin driver (pin driven low when oe=1, else 'z') and gates the receiver with busy.

Parameters:
- CLK_HZ, 24000000, clk_sys frequency in Hz.
- INHIBIT_US, 100, time the host holds clock low before request-to-send.
- START_TO_MS, 15, maximum wait for the first device clock after request-to-send.
- XFER_TO_MS, 2, maximum time from the first device clock to ACK.

Ports:
- clk_sys, in, 1, system clock.
- res_n_i, in, 1, asynchronous active-low reset.
- tx_data, in, 8, byte to send.
- tx_valid, in, 1, request; the byte is accepted when tx_valid & tx_ready.
- tx_ready, out, 1, idle and able to accept a byte.
- busy, out, 1, transaction in progress; the receiver ignores the bus while high.
- done, out, 1, one-cycle pulse when the device ACKed.
- err, out, 1, one-cycle pulse on timeout or missing ACK.
- ps2_clk_i, in, 1, raw PS/2 clock pin level (asynchronous).
- ps2_dat_i, in, 1, raw PS/2 data pin level (asynchronous).
- ps2_clk_oe, out, 1, 1 = pull the clock line low.
- ps2_dat_oe, out, 1, 1 = pull the data line low.

Behaviour:
- Reset values:
  - tx_ready=1; busy, done, err, ps2_clk_oe and ps2_dat_oe = 0.
  - FSM=IDLE, all counters 0.
  - Reset mid-transfer releases both lines immediately (asynchronous).
- Input conditioning:
  - ps2_clk_i and ps2_dat_i each pass through a 2-FF synchroniser, then an 8-cycle majority/stable filter.
  - fall = filtered clock 1→0, one-cycle strobe.
- Derived constants (localparam):
  - INH_CYC = CLK_HZ/1e6*INHIBIT_US (2400 at the defaults).
  - ST_CYC = CLK_HZ/1000*START_TO_MS.
  - XF_CYC = CLK_HZ/1000*XFER_TO_MS.
  - Timer width = $clog2 of the largest constant, plus 1.
- Frame: shift register {stop=1, parity=~^tx_data, tx_data} latched at acceptance. Data is sent LSB first.
- FSM:
  - IDLE: tx_ready=1. On tx_valid: latch the frame, busy=1, clk_oe=1, timer=0 → INHIBIT.
  - INHIBIT: clk_oe=1. When timer==INH_CYC-1: dat_oe=1 (start bit), then clk_oe=0 on the next cycle → RTS.
    - The data line must be low for at least 1 cycle before the clock is released.
  - RTS: wait for fall; timer counts toward ST_CYC.
    - On fall: drive bit0 (dat_oe=~bit), bit index=1, timer=0 → DATA.
    - On timeout → FAIL.
  - DATA: on each fall, drive the next frame bit (data bits 1..7, parity, stop).
    - Stop bit = dat_oe=0; stop is presented after the 10th fall.
    - After the stop bit is presented, the next fall → ACK.
  - ACK: on reaching this state, sample filtered data at that same fall.
    - Data 0 → WAIT_IDLE; data 1 → FAIL.
  - WAIT_IDLE: wait for filtered clock=1 and data=1 → DONE.
  - DONE: done=1 for 1 cycle, busy=0 → IDLE.
  - FAIL: release both lines, err=1 for 1 cycle, busy=0 → IDLE.
- XF_CYC timeout:
  - Active in DATA, ACK and WAIT_IDLE.
  - Timer is cleared on entry to DATA and is not cleared per bit.
  - Expiry → FAIL.
- tx_ready=0 from acceptance until the cycle after done or err.
- tx_valid is ignored while busy; no queueing.
- done and err are mutually exclusive and never both asserted.
- A fall during INHIBIT (device still clocking a byte) is ignored. Inhibit overrides the device, per protocol.
- ps2_clk_oe is never 1 outside INHIBIT.

Decomposition:
- Package ps2_pkg:
  - state enum: IDLE, INHIBIT, RTS, DATA, ACK, WAIT_IDLE, DONE, FAIL.
  - PS2 command constants: 0xED, 0xF4, 0xFF, 0xFE.
  - A function computing cycle counts from CLK_HZ.
- Sub-module ps2_line_filter: synchroniser, stable filter and fall strobe, one instance per line. It is reusable by the receiver.

Test Plan:
- Send 0xED.
  - Device model clocks at 80 µs period after seeing data low and clock released.
  - Clock held low ≥2400 cycles.
  - Bits driven 1,0,1,1,0,1,1,1, parity=1, stop=1.
  - Device ACK low → single done pulse; err=0; tx_ready returns 1.
- Send 0xF4 → parity bit 0 observed on the bus; done pulse.
- Request-to-send with no device clocks → err pulse at exactly ST_CYC cycles after clock release; both oe=0.
- Device clocks 5 bits then stops → err at XF_CYC after the first fall; lines released; next tx_valid accepted.
- Device leaves data high at the ACK clock → err pulse, no done.
- res_n_i asserted during DATA → clk_oe and dat_oe drop to 0 asynchronously; tx_ready=1 after release; a new 0xFF transfer completes with done.

Source files
------------

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared state type, command bytes and timing helper for the PS/2 host block
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        DATA,
        ACK,
        WAIT_IDLE,
        DONE,
        FAIL
    } ps2_tx_state_e;

    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
    localparam logic [7:0] PS2_CMD_RESEND   = 8'hFE;

    // data bits + parity + stop; the start bit is the request-to-send itself
    localparam int PS2_FRAME_BITS = 10;

    function automatic int ps2_cycles(input int clk_hz, input int amount, input int units_per_sec);
        return (clk_hz / units_per_sec) * amount;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// rtl/ps2_line_filter.sv - synchroniser, 8-sample stable filter and fall strobe for one PS/2 line
module ps2_line_filter (
    input  logic clk_sys,
    input  logic res_n_i,
    input  logic line_i,
    output logic level_o,
    output logic fall_o
);

    logic [1:0] sync_q, sync_d;
    logic [7:0] hist_q, hist_d;
    logic       level_q, level_d;
    logic       fall_q, fall_d;

    // an idle PS/2 bus floats high, so every stage resets to 1
    always_ff @(posedge clk_sys or negedge res_n_i) begin
        if (!res_n_i) begin
            sync_q  <= 2'b11;
            hist_q  <= 8'hFF;
            level_q <= 1'b1;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            hist_q  <= hist_d;
            level_q <= level_d;
            fall_q  <= fall_d;
        end
    end

    always_comb begin
        sync_d  = {sync_q[0], line_i};
        hist_d  = {hist_q[6:0], sync_q[1]};
        level_d = level_q;
        if (&hist_q) begin
            level_d = 1'b1;
        end else if (~|hist_q) begin
            level_d = 1'b0;
        end
        fall_d = level_q & ~level_d;
    end

    assign level_o = level_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device transmitter: request-to-send, framing, ACK check, timeouts
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int CLK_HZ      = 24_000_000,
    parameter int INHIBIT_US  = 100,
    parameter int START_TO_MS = 15,
    parameter int XFER_TO_MS  = 2
) (
    input  logic       clk_sys,
    input  logic       res_n_i,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       err,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe
);

    localparam int INH_CYC = ps2_cycles(CLK_HZ, INHIBIT_US, 1_000_000);
    localparam int ST_CYC  = ps2_cycles(CLK_HZ, START_TO_MS, 1_000);
    localparam int XF_CYC  = ps2_cycles(CLK_HZ, XFER_TO_MS, 1_000);
    localparam int MAX_CYC = (INH_CYC > ST_CYC) ? ((INH_CYC > XF_CYC) ? INH_CYC : XF_CYC)
                                                : ((ST_CYC > XF_CYC) ? ST_CYC : XF_CYC);
    localparam int TW      = $clog2(MAX_CYC) + 1;

    localparam logic [TW-1:0] T_ONE    = TW'(1);
    localparam logic [TW-1:0] INH_LAST = TW'(INH_CYC - 1);
    localparam logic [TW-1:0] INH_END  = TW'(INH_CYC);
    localparam logic [TW-1:0] ST_LAST  = TW'(ST_CYC - 1);
    localparam logic [TW-1:0] XF_LAST  = TW'(XF_CYC - 1);
    localparam logic [3:0]    LAST_BIT = 4'(PS2_FRAME_BITS);

    logic clk_lvl, clk_fall;
    logic dat_lvl;
    // the receiver consumes data-line falls; the transmitter only needs the level
    logic unused_dat_fall;

    ps2_line_filter u_clk_filter (
        .clk_sys (clk_sys),
        .res_n_i (res_n_i),
        .line_i  (ps2_clk_i),
        .level_o (clk_lvl),
        .fall_o  (clk_fall)
    );

    ps2_line_filter u_dat_filter (
        .clk_sys (clk_sys),
        .res_n_i (res_n_i),
        .line_i  (ps2_dat_i),
        .level_o (dat_lvl),
        .fall_o  (unused_dat_fall)
    );

    ps2_tx_state_e state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [9:0]    frame_q, frame_d;
    logic [3:0]    bit_idx_q, bit_idx_d;
    logic          dat_oe_q, dat_oe_d;
    logic          ack_q, ack_d;

    always_ff @(posedge clk_sys or negedge res_n_i) begin
        if (!res_n_i) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            frame_q   <= '0;
            bit_idx_q <= '0;
            dat_oe_q  <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            frame_q   <= frame_d;
            bit_idx_q <= bit_idx_d;
            dat_oe_q  <= dat_oe_d;
            ack_q     <= ack_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        frame_d   = frame_q;
        bit_idx_d = bit_idx_q;
        dat_oe_d  = dat_oe_q;
        ack_d     = ack_q;

        case (state_q)
            IDLE: begin
                timer_d  = '0;
                dat_oe_d = 1'b0;
                if (tx_valid) begin
                    frame_d   = {1'b1, ~^tx_data, tx_data};
                    bit_idx_d = '0;
                    state_d   = INHIBIT;
                end
            end

            // start bit goes low one cycle before the clock is let go
            INHIBIT: begin
                timer_d = timer_q + T_ONE;
                if (timer_q == INH_LAST) begin
                    dat_oe_d = 1'b1;
                end
                if (timer_q == INH_END) begin
                    timer_d = '0;
                    state_d = RTS;
                end
            end

            RTS: begin
                timer_d = timer_q + T_ONE;
                if (clk_fall) begin
                    dat_oe_d  = ~frame_q[0];
                    frame_d   = {1'b0, frame_q[9:1]};
                    bit_idx_d = 4'd1;
                    timer_d   = '0;
                    state_d   = DATA;
                end else if (timer_q == ST_LAST) begin
                    dat_oe_d = 1'b0;
                    state_d  = FAIL;
                end
            end

            DATA: begin
                timer_d = timer_q + T_ONE;
                if (timer_q == XF_LAST) begin
                    dat_oe_d = 1'b0;
                    state_d  = FAIL;
                end else if (clk_fall) begin
                    if (bit_idx_q == LAST_BIT) begin
                        ack_d   = dat_lvl;
                        state_d = ACK;
                    end else begin
                        dat_oe_d  = ~frame_q[0];
                        frame_d   = {1'b0, frame_q[9:1]};
                        bit_idx_d = bit_idx_q + 4'd1;
                    end
                end
            end

            ACK: begin
                timer_d = timer_q + T_ONE;
                if (timer_q == XF_LAST || ack_q) begin
                    dat_oe_d = 1'b0;
                    state_d  = FAIL;
                end else begin
                    state_d = WAIT_IDLE;
                end
            end

            WAIT_IDLE: begin
                timer_d = timer_q + T_ONE;
                if (timer_q == XF_LAST) begin
                    dat_oe_d = 1'b0;
                    state_d  = FAIL;
                end else if (clk_lvl && dat_lvl) begin
                    state_d = DONE;
                end
            end

            DONE: begin
                timer_d = '0;
                state_d = IDLE;
            end

            FAIL: begin
                timer_d  = '0;
                dat_oe_d = 1'b0;
                state_d  = IDLE;
            end

            default: begin
                timer_d  = '0;
                dat_oe_d = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    assign tx_ready   = (state_q == IDLE);
    assign busy       = (state_q == INHIBIT) || (state_q == RTS) || (state_q == DATA) ||
                        (state_q == ACK) || (state_q == WAIT_IDLE);
    assign done       = (state_q == DONE);
    assign err        = (state_q == FAIL);
    assign ps2_clk_oe = (state_q == INHIBIT);
    assign ps2_dat_oe = dat_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - scoreboard bench for ps2_host_tx with a behavioural PS/2 keyboard
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int CLK_HZ      = 1_000_000;
    localparam int INHIBIT_US  = 100;
    localparam int START_TO_MS = 15;
    localparam int XFER_TO_MS  = 2;
    localparam int INH_CYC     = CLK_HZ / 1_000_000 * INHIBIT_US;
    localparam int ST_CYC      = CLK_HZ / 1000 * START_TO_MS;
    localparam int XF_CYC      = CLK_HZ / 1000 * XFER_TO_MS;

    logic       clk_sys = 1'b0;
    logic       res_n_i = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, busy, done, err;
    logic       ps2_clk_i, ps2_dat_i, ps2_clk_oe, ps2_dat_oe;
    logic       dev_clk_low = 1'b0;
    logic       dev_dat_low = 1'b0;

    assign ps2_clk_i = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_dat_i = ~(ps2_dat_oe | dev_dat_low);

    ps2_host_tx #(
        .CLK_HZ      (CLK_HZ),
        .INHIBIT_US  (INHIBIT_US),
        .START_TO_MS (START_TO_MS),
        .XFER_TO_MS  (XFER_TO_MS)
    ) dut (
        .clk_sys    (clk_sys),
        .res_n_i    (res_n_i),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .ps2_clk_i  (ps2_clk_i),
        .ps2_dat_i  (ps2_dat_i),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe)
    );

    always #5 clk_sys = ~clk_sys;

    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    endtask

    // Reference: bits in wire order = 8 data bits LSB first, odd parity, stop
    function automatic logic [9:0] ref_frame(input logic [7:0] b);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, b};
    endfunction

    typedef struct {
        string      name;
        bit         exp_done;
        bit         chk_bits;
        logic [9:0] bits;
    } exp_t;
    exp_t sb_q[$];
    exp_t mon_e;
    int   resp_cnt = 0;

    // keyboard model: clocks the frame after seeing clock released with data low
    bit         dev_arm = 1'b0;
    bit         dev_abort = 1'b0;
    bit         dev_ack = 1'b1;
    int         dev_nclk = 0;
    int         dev_half = 40;
    int         dev_t = 0;
    int         dev_bit_cnt = 0;
    int         dev_fall_cyc = 0;
    logic [9:0] dev_bits = '0;

    task automatic dev_wait(input int n);
        for (int i = 0; i < n && !dev_abort; i++) @(negedge clk_sys);
    endtask

    initial begin : device_model
        forever begin
            wait (dev_arm);
            dev_t = 0;
            while (!(ps2_clk_i && !ps2_dat_i) && !dev_abort && dev_t < INH_CYC * 4) begin
                @(negedge clk_sys);
                dev_t++;
            end
            dev_wait(30);
            for (int k = 1; k <= dev_nclk; k++) begin
                if (dev_abort) break;
                dev_clk_low = 1'b1;
                if (k == 1) dev_fall_cyc = cyc;
                dev_wait(dev_half);
                dev_clk_low = 1'b0;
                if (k <= 10) begin
                    dev_bits[k-1] = ps2_dat_i;
                    dev_bit_cnt   = k;
                end
                if (k == 10 && dev_nclk == 11) begin
                    dev_wait(dev_half / 2);
                    dev_dat_low = dev_ack;
                    dev_wait(dev_half - dev_half / 2);
                end else begin
                    dev_wait(dev_half);
                end
            end
            dev_clk_low = 1'b0;
            dev_dat_low = 1'b0;
            dev_arm     = 1'b0;
        end
    end

    // monitor: pops the scoreboard on every done/err pulse and watches inhibit timing
    bit prev_pulse = 1'b0;
    bit ready_pending = 1'b0;
    bit last_dat_oe = 1'b0;
    int low_cnt = 0;
    int release_cyc = 0;
    int last_pulse_cyc = 0;

    initial begin : monitor
        forever begin
            @(negedge clk_sys);
            if (res_n_i) begin
                if (ready_pending) begin
                    check("tx_ready_after_pulse", tx_ready, 1);
                    ready_pending = 1'b0;
                end
                if (done || err) begin
                    check("done_err_exclusive", done & err, 0);
                    check("pulse_one_cycle", prev_pulse, 0);
                    if (sb_q.size() == 0) begin
                        total_cnt++;
                        $display("FAIL unexpected_response: done=%0b err=%0b, nothing queued", done, err);
                    end else begin
                        mon_e = sb_q.pop_front();
                        check({mon_e.name, "_done"}, done, mon_e.exp_done);
                        check({mon_e.name, "_err"}, err, !mon_e.exp_done);
                        if (!mon_e.exp_done)
                            check({mon_e.name, "_lines_released"}, {ps2_clk_oe, ps2_dat_oe}, 0);
                        if (mon_e.chk_bits)
                            check({mon_e.name, "_frame_bits"}, dev_bits, mon_e.bits);
                    end
                    resp_cnt++;
                    ready_pending  = 1'b1;
                    last_pulse_cyc = cyc;
                end
                if (ps2_clk_oe) begin
                    low_cnt++;
                    last_dat_oe = ps2_dat_oe;
                end else if (low_cnt > 0) begin
                    check("inhibit_long_enough", low_cnt >= INH_CYC, 1);
                    check("start_bit_before_release", last_dat_oe, 1);
                    release_cyc = cyc;
                    low_cnt     = 0;
                end
            end
            prev_pulse = done | err;
        end
    end

    task automatic send(input logic [7:0] b, input int nclk, input bit ack, input int half,
                        input int hold, input string name);
        exp_t e;
        int   target;
        int   t;
        e.name     = name;
        e.exp_done = (nclk == 11) && ack;
        e.chk_bits = (nclk == 11);
        e.bits     = ref_frame(b);
        sb_q.push_back(e);
        target      = resp_cnt + 1;
        dev_nclk    = nclk;
        dev_ack     = ack;
        dev_half    = half;
        dev_bits    = '0;
        dev_bit_cnt = 0;
        if (nclk > 0) dev_arm = 1'b1;
        @(negedge clk_sys);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk_sys);
        check({name, "_accepted"}, tx_ready, 0);
        check({name, "_busy"}, busy, 1);
        if (hold > 0) begin
            tx_data = ~b;
            repeat (hold) @(negedge clk_sys);
        end
        tx_valid = 1'b0;
        t = 0;
        while (resp_cnt < target && t < ST_CYC + 5000) begin
            @(negedge clk_sys);
            t++;
        end
        check({name, "_response_seen"}, resp_cnt, target);
        t = 0;
        while (dev_arm && t < 3000) begin
            @(negedge clk_sys);
            t++;
        end
        check({name, "_device_idle"}, dev_arm, 0);
        repeat (20) @(negedge clk_sys);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", pass_cnt, total_cnt);
        $fatal(1);
    end

    logic [7:0] cmds [4];
    logic [7:0] rb;
    int         t_main;

    initial begin : stimulus
        cmds[0] = PS2_CMD_SET_LEDS;
        cmds[1] = PS2_CMD_ENABLE;
        cmds[2] = PS2_CMD_RESET;
        cmds[3] = PS2_CMD_RESEND;

        repeat (3) @(negedge clk_sys);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_clk_oe", ps2_clk_oe, 0);
        check("rst_dat_oe", ps2_dat_oe, 0);
        res_n_i = 1'b1;
        repeat (20) @(negedge clk_sys);

        send(PS2_CMD_SET_LEDS, 11, 1'b1, 40, 0, "ed");
        check("ed_parity_bit", dev_bits[8], 1);
        send(PS2_CMD_ENABLE, 11, 1'b1, 40, 0, "f4");
        check("f4_parity_bit", dev_bits[8], 0);

        send(8'hA5, 0, 1'b1, 40, 0, "no_clock");
        check("start_timeout_cycles", last_pulse_cyc - release_cyc, ST_CYC);

        send(8'h5A, 5, 1'b1, 40, 0, "stall5");
        check("xfer_timeout_window",
              (last_pulse_cyc - dev_fall_cyc >= XF_CYC) && (last_pulse_cyc - dev_fall_cyc <= XF_CYC + 20), 1);

        send(8'h3C, 11, 1'b0, 40, 0, "no_ack");

        // reset in the middle of DATA while the host is pulling data low
        dev_nclk    = 11;
        dev_ack     = 1'b1;
        dev_half    = 40;
        dev_bit_cnt = 0;
        dev_arm     = 1'b1;
        @(negedge clk_sys);
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        @(negedge clk_sys);
        tx_valid = 1'b0;
        t_main = 0;
        while (dev_bit_cnt < 4 && t_main < 3000) begin
            @(negedge clk_sys);
            t_main++;
        end
        check("rst_mid_reached_data", dev_bit_cnt, 4);
        check("rst_mid_dat_oe_before", ps2_dat_oe, 1);
        #2;
        res_n_i = 1'b0;
        #1;
        check("rst_mid_clk_oe_async", ps2_clk_oe, 0);
        check("rst_mid_dat_oe_async", ps2_dat_oe, 0);
        dev_abort = 1'b1;
        t_main = 0;
        while (dev_arm && t_main < 3000) begin
            @(negedge clk_sys);
            t_main++;
        end
        repeat (3) @(negedge clk_sys);
        res_n_i = 1'b1;
        @(negedge clk_sys);
        check("rst_mid_tx_ready", tx_ready, 1);
        check("rst_mid_busy", busy, 0);
        dev_abort = 1'b0;
        repeat (20) @(negedge clk_sys);

        send(PS2_CMD_RESET, 11, 1'b1, 40, 0, "ff_after_reset");

        for (int i = 0; i < 6; i++) begin
            rb = ($urandom_range(0, 1) == 0) ? cmds[$urandom_range(0, 3)] : 8'($urandom_range(0, 255));
            send(rb, 11, ($urandom_range(0, 3) != 0), $urandom_range(30, 50), (i == 2) ? 150 : 0, "rand");
        end

        check("scoreboard_drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
